// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package cpu_pkg;

    localparam int         WIDTH    = 16;
    localparam logic [3:0] FUNC_MUL = 4'hE;
    localparam logic [3:0] FUNC_DIV = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    function automatic logic is_muldiv(input logic [3:0] f);
        return (f == FUNC_MUL) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// MUL: {acc, shreg} is the growing product, shreg starts as the multiplier.
// DIV: acc is the partial remainder, shreg shifts the dividend out and the quotient in.
module muldiv_iter
    import cpu_pkg::*;
(
    input  mode_t            mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Single step; the divide subtract cannot overflow 17 bits because the remainder stays below the divisor.
    always_comb begin
        sum        = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        shifted    = {acc, shreg[WIDTH-1]};
        diff       = shifted - {1'b0, operand};
        acc_next   = acc;
        shreg_next = shreg;
        if (mode == MODE_MUL) begin
            acc_next   = sum[WIDTH:1];
            shreg_next = {sum[0], shreg[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_next   = diff[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next   = shifted[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage signed 16x16 multiply / 16/16 divide with pipeline stall.
//  state | meaning
//  IDLE  | waiting for a MUL/DIV start from ID/EX
//  RUN   | iterating on operand magnitudes, count 0..15
//  DONE  | signed result presented, done pulse, pipeline released
module ex_muldiv_unit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resHi,
    output logic [WIDTH-1:0] resLo,
    output logic             divByZero
);

    state_t             state, state_next;
    logic [4:0]         cnt;
    mode_t              mode;
    logic [WIDTH-1:0]   acc, shreg, operand;
    logic [WIDTH-1:0]   acc_step, shreg_step;
    logic               sign_q, sign_r, dbz_flag;
    logic [WIDTH-1:0]   held_hi, held_lo;
    logic               accept, zero_div, last_iter;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic [WIDTH-1:0]   final_hi, final_lo;

    assign accept    = (state == ST_IDLE) && start && is_muldiv(func) && !flush;
    assign zero_div  = (func == FUNC_DIV) && (opB == '0);
    assign last_iter = (cnt == 5'(WIDTH - 1));
    assign mag_a     = opA[WIDTH-1] ? -opA : opA;
    assign mag_b     = opB[WIDTH-1] ? -opB : opB;

    muldiv_iter u_iter (
        .mode       (mode),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .acc_next   (acc_step),
        .shreg_next (shreg_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; divide by zero skips RUN entirely.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = zero_div ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (flush)          state_next = ST_IDLE;
                else if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs; a flush in DONE suppresses the pulse and keeps the previous result visible.
    always_comb begin
        stall     = accept || (state == ST_RUN);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE) && !flush;
        divByZero = done && dbz_flag;
        resHi     = done ? final_hi : held_hi;
        resLo     = done ? final_lo : held_lo;
    end

    // Iteration counter, restarted on every accepted operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              cnt <= '0;
        else if (accept)                       cnt <= '0;
        else if (state == ST_RUN && !last_iter) cnt <= cnt + 5'd1;
    end

    // Operand capture as magnitudes plus result signs; divide by zero preloads the fixed answer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= MODE_MUL;
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_flag <= 1'b0;
        end else if (accept) begin
            sign_q   <= opA[WIDTH-1] ^ opB[WIDTH-1];
            sign_r   <= opA[WIDTH-1];
            dbz_flag <= 1'b0;
            acc      <= '0;
            if (func == FUNC_MUL) begin
                mode    <= MODE_MUL;
                shreg   <= mag_b;
                operand <= mag_a;
            end else if (zero_div) begin
                mode     <= MODE_DIV;
                acc      <= opA;
                shreg    <= '1;
                operand  <= opB;
                sign_q   <= 1'b0;
                sign_r   <= 1'b0;
                dbz_flag <= 1'b1;
            end else begin
                mode    <= MODE_DIV;
                shreg   <= mag_a;
                operand <= mag_b;
            end
        end else if (state == ST_RUN && !flush) begin
            acc   <= acc_step;
            shreg <= shreg_step;
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        prod_mag    = {acc, shreg};
        prod_signed = sign_q ? -prod_mag : prod_mag;
        final_hi    = sign_r ? -acc : acc;
        final_lo    = sign_q ? -shreg : shreg;
        if (mode == MODE_MUL) begin
            final_hi = prod_signed[2*WIDTH-1:WIDTH];
            final_lo = prod_signed[WIDTH-1:0];
        end
    end

    // Result hold registers, updated only on a delivered done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_hi <= '0;
            held_lo <= '0;
        end else if (done) begin
            held_hi <= final_hi;
            held_lo <= final_lo;
        end
    end

endmodule
